exception_ctrl: RTL and testbench

Next-generation precise exception/interrupt controller at the commit stage of the MIPS pipeline. It synchronises a parametrised set of hardware interrupt lines, gates them with CP0 Status, priority-encodes commit-stage exception flags, and records cause, EPC and BadVAddr. It then holds a registered redirect/flush request until the pipeline acknowledges it. ERET redirect is handled in the same path, replacing the previous purely combinational encoder.

---
 rtl/common_pkg.sv | 13 +
 rtl/exception_pkg.sv | 49 ++++
 rtl/int_sync.sv | 22 ++
 rtl/exception_ctrl.sv | 112 +++++++++++
 tb/tb_exception_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/common_pkg.sv
// common_pkg: CP0 types shared across the core.
package common_pkg;

    // CP0 Status fields the exception path needs; im[7:0] masks Cause.IP[7:0].
    typedef struct packed {
        logic [7:0] im;
        logic       bev;
        logic       erl;
        logic       exl;
        logic       ie;
    } cp0_status_t;

endpackage

// File: rtl/exception_pkg.sv
// exception_pkg: exception codes, commit flags, CP0 record and FSM state for exception_ctrl.
package exception_pkg;

    typedef enum logic [4:0] {
        CODE_INT  = 5'h00,
        CODE_ADEL = 5'h04,
        CODE_ADES = 5'h05,
        CODE_SYS  = 5'h08,
        CODE_BP   = 5'h09,
        CODE_RI   = 5'h0A,
        CODE_OV   = 5'h0C
    } exc_code_t;

    typedef struct packed {
        logic adel_if;
        logic ri;
        logic ov;
        logic sys;
        logic bp;
        logic adel_ld;
        logic ades;
    } exc_flags_t;

    typedef struct packed {
        exc_code_t   code;
        logic [31:0] pc;
        logic        in_delay_slot;
        logic [31:0] badvaddr;
        logic        badvaddr_we;
    } exc_record_t;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } exc_state_t;

    // Highest priority first; the fetch fault outranks decode/execute faults,
    // which outrank memory-stage faults.
    function automatic exc_code_t exc_code(input logic intr, input exc_flags_t f);
        return intr      ? CODE_INT  :
               f.adel_if ? CODE_ADEL :
               f.ri      ? CODE_RI   :
               f.ov      ? CODE_OV   :
               f.sys     ? CODE_SYS  :
               f.bp      ? CODE_BP   :
               f.adel_ld ? CODE_ADEL : CODE_ADES;
    endfunction

endpackage

// File: rtl/int_sync.sv
// int_sync: per-bit multi-flop synchroniser for asynchronous level inputs.
// Ports: i_clk, i_reset (async, active-high), i_d[W] raw lines, o_q[W] synchronised lines.
module int_sync #(
    parameter int W     = 6,
    parameter int DEPTH = 2
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [DEPTH-1:0][W-1:0] r_sync;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_sync <= '0;
        else         r_sync <= {r_sync[DEPTH-2:0], i_d};
    end

    assign o_q = r_sync[DEPTH-1];

endmodule

// File: rtl/exception_ctrl.sv
// exception_ctrl: commit-stage precise exception/interrupt/ERET controller with registered redirect.
// Ports: i_clk, i_reset (async, active-high); i_hw_int/i_sw_int/i_status interrupt sources and mask;
//   i_commit_* describe the committing instruction; i_epc current EPC; o_redirect_valid/o_redirect_pc
//   held until i_flush_ack; o_cp0_wr/o_cp0_clr_exl one-cycle CP0 update pulses with o_cp0_rec;
//   o_hw_int_sync feeds Cause.IP[7:2]; o_busy stalls commit while a redirect is outstanding.
module exception_ctrl
    import common_pkg::*;
    import exception_pkg::*;
#(
    parameter int          N_HWINT     = 6,
    parameter int          SYNC_STAGES = 2,
    parameter logic [31:0] BEV_BASE    = 32'hBFC0_0200,
    parameter logic [31:0] NORM_BASE   = 32'h8000_0000,
    parameter logic [11:0] VEC_OFFSET  = 12'h180
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [N_HWINT-1:0] i_hw_int,
    input  logic [1:0]         i_sw_int,
    input  cp0_status_t        i_status,
    input  logic               i_commit_valid,
    input  logic [31:0]        i_commit_pc,
    input  logic               i_commit_in_delay_slot,
    input  logic [31:0]        i_commit_vaddr,
    input  exc_flags_t         i_commit_flags,
    input  logic               i_commit_eret,
    input  logic [31:0]        i_epc,
    output logic               o_redirect_valid,
    output logic [31:0]        o_redirect_pc,
    input  logic               i_flush_ack,
    output logic               o_cp0_wr,
    output logic               o_cp0_clr_exl,
    output exc_record_t        o_cp0_rec,
    output logic [N_HWINT-1:0] o_hw_int_sync,
    output logic               o_busy
);

    exc_state_t          r_state, w_next;
    logic [31:0]         r_redirect_pc;
    exc_record_t         r_rec;
    logic                r_wr, r_clr;
    logic [N_HWINT-1:0]  w_hw_sync;
    logic [N_HWINT+1:0]  w_ip;
    logic                w_int_pending, w_exc, w_idle_commit, w_take_exc, w_take_eret;
    logic                w_bv_we;
    exc_code_t           w_code;
    logic [31:0]         w_vector, w_badvaddr;

    int_sync #(.W(N_HWINT), .DEPTH(SYNC_STAGES)) u_sync (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_hw_int),
        .o_q     (w_hw_sync)
    );

    assign w_ip          = {w_hw_sync, i_sw_int};
    assign w_int_pending = |(w_ip & i_status.im[N_HWINT+1:0]) & i_status.ie & ~i_status.exl & ~i_status.erl;
    assign w_exc         = |i_commit_flags;
    // Commit inputs are only looked at in IDLE; hazard logic stalls commit otherwise.
    assign w_idle_commit = (r_state == ST_IDLE) & i_commit_valid;
    assign w_take_exc    = w_idle_commit & (w_exc | w_int_pending);
    assign w_take_eret   = w_idle_commit & i_commit_eret & ~w_exc & ~w_int_pending;
    assign w_code        = exc_code(w_int_pending, i_commit_flags);
    assign w_bv_we       = (w_code == CODE_ADEL) | (w_code == CODE_ADES);
    // An ADEL that survives priority with adel_if set is the fetch fault, so the PC is the bad address.
    assign w_badvaddr    = !w_bv_we ? 32'h0 :
                           (~w_int_pending & i_commit_flags.adel_if) ? i_commit_pc : i_commit_vaddr;
    assign w_vector      = (i_status.bev ? BEV_BASE : NORM_BASE) + 32'(VEC_OFFSET);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (r_state == ST_IDLE) w_next = (w_take_exc | w_take_eret) ? ST_REDIRECT : ST_IDLE;
        else                    w_next = i_flush_ack ? ST_IDLE : ST_REDIRECT;
    end

    always_comb begin
        o_redirect_valid = (r_state == ST_REDIRECT);
        o_busy           = (r_state != ST_IDLE);
    end

    // Redirect target and CP0 record are captured on acceptance and held through REDIRECT.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_redirect_pc <= '0;
            r_rec         <= '0;
            r_wr          <= 1'b0;
            r_clr         <= 1'b0;
        end else begin
            r_wr  <= w_take_exc;
            r_clr <= w_take_eret;
            if (w_take_exc) begin
                r_redirect_pc <= w_vector;
                r_rec         <= '{code: w_code, pc: i_commit_pc, in_delay_slot: i_commit_in_delay_slot,
                                   badvaddr: w_badvaddr, badvaddr_we: w_bv_we};
            end else if (w_take_eret) begin
                r_redirect_pc <= i_epc;
            end
        end
    end

    assign o_redirect_pc = r_redirect_pc;
    assign o_cp0_rec     = r_rec;
    assign o_cp0_wr      = r_wr;
    assign o_cp0_clr_exl = r_clr;
    assign o_hw_int_sync = w_hw_sync;

endmodule

// File: tb/tb_exception_ctrl.sv
// tb_exception_ctrl: table-driven plus directed corner-case bench for exception_ctrl.
module tb_exception_ctrl;
    import common_pkg::*;
    import exception_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [5:0]  hw_int = '0;
    logic [1:0]  sw_int = '0;
    cp0_status_t status = '0;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_pc = '0;
    logic        commit_ds = 1'b0;
    logic [31:0] commit_vaddr = '0;
    exc_flags_t  commit_flags = '0;
    logic        commit_eret = 1'b0;
    logic [31:0] epc = '0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush_ack = 1'b0;
    logic        cp0_wr, cp0_clr_exl, busy;
    exc_record_t cp0_rec;
    logic [5:0]  hw_int_sync;

    int n_chk = 0;
    int n_fail = 0;

    exception_ctrl dut (
        .i_clk                  (clk),
        .i_reset                (reset),
        .i_hw_int               (hw_int),
        .i_sw_int               (sw_int),
        .i_status               (status),
        .i_commit_valid         (commit_valid),
        .i_commit_pc            (commit_pc),
        .i_commit_in_delay_slot (commit_ds),
        .i_commit_vaddr         (commit_vaddr),
        .i_commit_flags         (commit_flags),
        .i_commit_eret          (commit_eret),
        .i_epc                  (epc),
        .o_redirect_valid       (redirect_valid),
        .o_redirect_pc          (redirect_pc),
        .i_flush_ack            (flush_ack),
        .o_cp0_wr               (cp0_wr),
        .o_cp0_clr_exl          (cp0_clr_exl),
        .o_cp0_rec              (cp0_rec),
        .o_hw_int_sync          (hw_int_sync),
        .o_busy                 (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [1:0]  sw;
        cp0_status_t st;
        exc_flags_t  fl;
        logic        eret;
        logic [31:0] pc;
        logic [31:0] va;
        logic [31:0] epc;
        logic        ds;
        logic        redir;
        logic        wr;
        logic        clr;
        logic [4:0]  code;
        logic [31:0] rpc;
        logic [31:0] bv;
        logic        bvwe;
    } vec_t;

    vec_t vq[$];

    function automatic cp0_status_t mk_st(input logic [7:0] a_im, input logic a_bev, input logic a_erl,
                                          input logic a_exl, input logic a_ie);
        cp0_status_t s;
        s.im  = a_im;
        s.bev = a_bev;
        s.erl = a_erl;
        s.exl = a_exl;
        s.ie  = a_ie;
        return s;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic commit1(input logic [31:0] pc, input logic [6:0] fl, input logic er,
                           input logic [31:0] ep, input logic [31:0] va, input logic ds);
        @(negedge clk);
        commit_pc    = pc;
        commit_flags = exc_flags_t'(fl);
        commit_eret  = er;
        epc          = ep;
        commit_vaddr = va;
        commit_ds    = ds;
        commit_valid = 1'b1;
        @(negedge clk);
        commit_valid = 1'b0;
        commit_flags = '0;
        commit_eret  = 1'b0;
        epc          = 32'hDEAD_BEEF;
    endtask

    task automatic ack1();
        flush_ack = 1'b1;
        @(negedge clk);
        flush_ack = 1'b0;
    endtask

    initial begin
        cp0_status_t b0, b1;
        b0 = mk_st(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        b1 = mk_st(8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
        //          sw     status                        flags       er  pc            va            epc           ds redir wr clr code   rpc           bv            bvwe
        vq.push_back('{2'b00, b0, 7'b0010001, 0, 32'h8000_0400, 32'h0000_1234, 32'h0, 0, 1, 1, 0, 5'h0C, 32'h8000_0180, 32'h0, 0});
        vq.push_back('{2'b00, b1, 7'b0000010, 0, 32'h8000_0500, 32'h0000_1003, 32'h0, 1, 1, 1, 0, 5'h04, 32'hBFC0_0380, 32'h0000_1003, 1});
        vq.push_back('{2'b00, b0, 7'b1100000, 0, 32'h0000_0002, 32'h0000_5555, 32'h0, 0, 1, 1, 0, 5'h04, 32'h8000_0180, 32'h0000_0002, 1});
        vq.push_back('{2'b00, b0, 7'b0110000, 0, 32'h8000_0700, 32'h0, 32'h0, 0, 1, 1, 0, 5'h0A, 32'h8000_0180, 32'h0, 0});
        vq.push_back('{2'b00, b0, 7'b0001100, 0, 32'h8000_0704, 32'h0, 32'h0, 1, 1, 1, 0, 5'h08, 32'h8000_0180, 32'h0, 0});
        vq.push_back('{2'b00, b1, 7'b0000100, 0, 32'h8000_0708, 32'h0, 32'h0, 0, 1, 1, 0, 5'h09, 32'hBFC0_0380, 32'h0, 0});
        vq.push_back('{2'b00, b0, 7'b0000001, 0, 32'h8000_070C, 32'h7FFF_FFFE, 32'h0, 0, 1, 1, 0, 5'h05, 32'h8000_0180, 32'h7FFF_FFFE, 1});
        vq.push_back('{2'b00, b0, 7'b0000000, 1, 32'h8000_0710, 32'h0, 32'h8000_2000, 0, 1, 0, 1, 5'h00, 32'h8000_2000, 32'h0, 0});
        vq.push_back('{2'b00, b0, 7'b0001000, 1, 32'h8000_0714, 32'h0, 32'h8000_3000, 0, 1, 1, 0, 5'h08, 32'h8000_0180, 32'h0, 0});
        vq.push_back('{2'b00, b0, 7'b0000000, 0, 32'h8000_0718, 32'h0, 32'h0, 0, 0, 0, 0, 5'h00, 32'h0, 32'h0, 0});
        vq.push_back('{2'b01, mk_st(8'h01, 0, 0, 0, 1), 7'b0000000, 0, 32'h8000_0600, 32'h0, 32'h0, 0, 1, 1, 0, 5'h00, 32'h8000_0180, 32'h0, 0});
        vq.push_back('{2'b10, mk_st(8'h01, 0, 0, 0, 1), 7'b0000000, 0, 32'h8000_0604, 32'h0, 32'h0, 0, 0, 0, 0, 5'h00, 32'h0, 32'h0, 0});
        vq.push_back('{2'b01, mk_st(8'h01, 0, 1, 0, 1), 7'b0000000, 0, 32'h8000_0608, 32'h0, 32'h0, 0, 0, 0, 0, 5'h00, 32'h0, 32'h0, 0});
        vq.push_back('{2'b01, mk_st(8'h01, 0, 0, 0, 0), 7'b0001000, 0, 32'h8000_060C, 32'h0, 32'h0, 0, 1, 1, 0, 5'h08, 32'h8000_0180, 32'h0, 0});
        vq.push_back('{2'b11, mk_st(8'h02, 1, 0, 0, 1), 7'b1000000, 0, 32'h0000_0001, 32'h0, 32'h0, 0, 1, 1, 0, 5'h00, 32'hBFC0_0380, 32'h0, 0});
        vq.push_back('{2'b01, mk_st(8'hFE, 0, 0, 0, 1), 7'b0000000, 0, 32'h8000_0610, 32'h0, 32'h0, 0, 0, 0, 0, 5'h00, 32'h0, 32'h0, 0});

        // Reset state
        repeat (2) @(negedge clk);
        check("rst redirect_valid", {31'b0, redirect_valid}, 32'h0);
        check("rst redirect_pc", redirect_pc, 32'h0);
        check("rst cp0_wr", {31'b0, cp0_wr}, 32'h0);
        check("rst cp0_clr_exl", {31'b0, cp0_clr_exl}, 32'h0);
        check("rst busy", {31'b0, busy}, 32'h0);
        check("rst hw_int_sync", {26'b0, hw_int_sync}, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Table-driven single-commit transactions
        foreach (vq[i]) begin
            sw_int = vq[i].sw;
            status = vq[i].st;
            commit1(vq[i].pc, vq[i].fl, vq[i].eret, vq[i].epc, vq[i].va, vq[i].ds);
            check($sformatf("v%0d redirect_valid", i), {31'b0, redirect_valid}, {31'b0, vq[i].redir});
            check($sformatf("v%0d busy", i), {31'b0, busy}, {31'b0, vq[i].redir});
            check($sformatf("v%0d cp0_wr", i), {31'b0, cp0_wr}, {31'b0, vq[i].wr});
            check($sformatf("v%0d cp0_clr_exl", i), {31'b0, cp0_clr_exl}, {31'b0, vq[i].clr});
            if (vq[i].redir) check($sformatf("v%0d redirect_pc", i), redirect_pc, vq[i].rpc);
            if (vq[i].wr) begin
                check($sformatf("v%0d code", i), {27'b0, cp0_rec.code}, {27'b0, vq[i].code});
                check($sformatf("v%0d rec.pc", i), cp0_rec.pc, vq[i].pc);
                check($sformatf("v%0d rec.ds", i), {31'b0, cp0_rec.in_delay_slot}, {31'b0, vq[i].ds});
                check($sformatf("v%0d badvaddr_we", i), {31'b0, cp0_rec.badvaddr_we}, {31'b0, vq[i].bvwe});
                if (vq[i].bvwe) check($sformatf("v%0d badvaddr", i), cp0_rec.badvaddr, vq[i].bv);
            end
            if (vq[i].redir) begin
                ack1();
                check($sformatf("v%0d post-ack redirect_valid", i), {31'b0, redirect_valid}, 32'h0);
            end
        end
        sw_int = '0;

        // Hardware interrupt through the synchroniser
        status = mk_st(8'h04, 1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        hw_int = 6'b000001;
        @(negedge clk);
        check("hw sync stage1", {26'b0, hw_int_sync}, 32'h0);
        @(negedge clk);
        check("hw sync stage2", {26'b0, hw_int_sync}, 32'h1);
        check("hw no commit no redirect", {31'b0, redirect_valid}, 32'h0);
        commit1(32'hBFC0_0100, 7'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("hw redirect_pc", redirect_pc, 32'hBFC0_0380);
        check("hw code", {27'b0, cp0_rec.code}, 32'h0);
        check("hw rec.pc", cp0_rec.pc, 32'hBFC0_0100);
        check("hw cp0_wr", {31'b0, cp0_wr}, 32'h1);
        @(negedge clk);
        check("hw cp0_wr single pulse", {31'b0, cp0_wr}, 32'h0);
        check("hw redirect held", {31'b0, redirect_valid}, 32'h1);
        ack1();

        // Interrupt masked by EXL stays pending and is taken once EXL clears
        status.exl = 1'b1;
        commit1(32'h8000_1000, 7'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("exl no redirect", {31'b0, redirect_valid}, 32'h0);
        status.exl = 1'b0;
        @(negedge clk);
        check("exl clear no commit", {31'b0, redirect_valid}, 32'h0);
        commit1(32'h8000_1004, 7'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        check("exl cleared redirect", {31'b0, redirect_valid}, 32'h1);
        check("exl cleared code", {27'b0, cp0_rec.code}, 32'h0);
        check("exl cleared rec.pc", cp0_rec.pc, 32'h8000_1004);
        ack1();
        hw_int = '0;
        repeat (3) @(negedge clk);

        // ERET with flush_ack delayed three cycles; commits during REDIRECT ignored
        status = mk_st(8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        commit1(32'h8000_0800, 7'b0, 1'b1, 32'h8000_2000, 32'h0, 1'b0);
        check("eret redirect_pc", redirect_pc, 32'h8000_2000);
        check("eret clr_exl", {31'b0, cp0_clr_exl}, 32'h1);
        check("eret no cp0_wr", {31'b0, cp0_wr}, 32'h0);
        commit_valid = 1'b1;
        commit_flags = exc_flags_t'(7'b0001000);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("eret hold%0d redirect_valid", k), {31'b0, redirect_valid}, 32'h1);
            check($sformatf("eret hold%0d busy", k), {31'b0, busy}, 32'h1);
            check($sformatf("eret hold%0d redirect_pc", k), redirect_pc, 32'h8000_2000);
            check($sformatf("eret hold%0d clr_exl", k), {31'b0, cp0_clr_exl}, 32'h0);
            check($sformatf("eret hold%0d cp0_wr", k), {31'b0, cp0_wr}, 32'h0);
        end
        commit_valid = 1'b0;
        commit_flags = '0;
        ack1();
        check("eret post-ack redirect_valid", {31'b0, redirect_valid}, 32'h0);
        check("eret post-ack busy", {31'b0, busy}, 32'h0);

        // flush_ack in the same cycle redirect_valid rises
        status = mk_st(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        commit1(32'h8000_0900, 7'b0001000, 1'b0, 32'h0, 32'h0, 1'b0);
        check("fast ack redirect_valid", {31'b0, redirect_valid}, 32'h1);
        ack1();
        check("fast ack idle", {31'b0, busy}, 32'h0);
        check("fast ack cp0_wr", {31'b0, cp0_wr}, 32'h0);

        // Asynchronous reset during REDIRECT
        commit1(32'h8000_0A00, 7'b0000100, 1'b0, 32'h0, 32'h0, 1'b0);
        check("pre-reset redirect_valid", {31'b0, redirect_valid}, 32'h1);
        #2 reset = 1'b1;
        #1;
        check("async reset redirect_valid", {31'b0, redirect_valid}, 32'h0);
        check("async reset cp0_wr", {31'b0, cp0_wr}, 32'h0);
        check("async reset redirect_pc", redirect_pc, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post-reset busy", {31'b0, busy}, 32'h0);
        check("post-reset redirect_valid", {31'b0, redirect_valid}, 32'h0);
        check("post-reset cp0_wr", {31'b0, cp0_wr}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
